// File: rtl/seq_divider32_if.sv
// Divider request/response bundle between the control unit (master) and seq_divider32 (slave).
// unsignedOp exists only when SEQ_DIV_UNSIGNED_EN is defined.
interface seq_divider32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SEQ_DIV_UNSIGNED_EN
  logic             unsignedOp;
`endif
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] zlowOut;
  logic [WIDTH-1:0] zhighOut;

`ifdef SEQ_DIV_UNSIGNED_EN
  modport master (output start, A, B, unsignedOp,
                  input  busy, done, divByZero, zlowOut, zhighOut);
  modport slave  (input  start, A, B, unsignedOp,
                  output busy, done, divByZero, zlowOut, zhighOut);
`else
  modport master (output start, A, B,
                  input  busy, done, divByZero, zlowOut, zhighOut);
  modport slave  (input  start, A, B,
                  output busy, done, divByZero, zlowOut, zhighOut);
`endif
endinterface

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider: one quotient bit per clock, quotient on zlowOut, remainder on zhighOut.
// Optional unsigned mode via macro SEQ_DIV_UNSIGNED_EN (adds unsignedOp to the interface).
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             clear,
  seq_divider32_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       stateReg;
  logic [CW-1:0]    countReg;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             negQuoReg;
  logic             negRemReg;
  logic             zeroReg;
  logic             busyReg;
  logic             doneReg;
  logic             divByZeroReg;
  logic [WIDTH-1:0] zlowReg;
  logic [WIDTH-1:0] zhighReg;

  logic             opSigned;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
`ifdef SEQ_DIV_UNSIGNED_EN
    opSigned = !bus.unsignedOp;
`else
    opSigned = 1'b1;
`endif
    signA = opSigned & bus.A[WIDTH-1];
    signB = opSigned & bus.B[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    absA  = signA ? -bus.A : bus.A;
    absB  = signB ? -bus.B : bus.B;
    // WIDTH+1-bit partial remainder; its MSB after subtraction is the restore decision
    shifted = {remReg, quoReg[WIDTH-1]};
    trial   = shifted - {1'b0, divisorReg};
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stateReg     <= IDLE;
      countReg     <= '0;
      remReg       <= '0;
      quoReg       <= '0;
      divisorReg   <= '0;
      negQuoReg    <= 1'b0;
      negRemReg    <= 1'b0;
      zeroReg      <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      divByZeroReg <= 1'b0;
      zlowReg      <= '0;
      zhighReg     <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            busyReg      <= 1'b1;
            divByZeroReg <= 1'b0;
            quoReg       <= absA;
            divisorReg   <= absB;
            remReg       <= '0;
            negQuoReg    <= signA ^ signB;
            negRemReg    <= signA;
            zeroReg      <= (bus.B == '0);
            countReg     <= CW'(WIDTH - 1);
            stateReg     <= (bus.B == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          if (trial[WIDTH]) begin
            remReg <= shifted[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b0};
          end else begin
            remReg <= trial[WIDTH-1:0];
            quoReg <= {quoReg[WIDTH-2:0], 1'b1};
          end
          countReg <= countReg - 1'b1;
          if (countReg == '0)
            stateReg <= FIX;
        end
        FIX: begin
          // On divide-by-zero quoReg still holds |A|, so re-signing it restores A
          if (zeroReg) begin
            zlowReg      <= '1;
            zhighReg     <= negRemReg ? -quoReg : quoReg;
            divByZeroReg <= 1'b1;
          end else begin
            zlowReg  <= negQuoReg ? -quoReg : quoReg;
            zhighReg <= negRemReg ? -remReg : remReg;
          end
          doneReg  <= 1'b1;
          busyReg  <= 1'b0;
          stateReg <= IDLE;
        end
        default: begin
          busyReg  <= 1'b0;
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.divByZero = divByZeroReg;
  assign bus.zlowOut   = zlowReg;
  assign bus.zhighOut  = zhighReg;
endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32: sign cases, overflow, divide-by-zero, ignored starts, abort.
module tb_seq_divider32;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clock = ~clock;

  seq_divider32_if #(.WIDTH(32)) bus ();

  seq_divider32 #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Entered and left one time unit after a rising edge
  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expQ, input logic [31:0] expR,
                       input logic expDz, input int expLat);
    int edges;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    checkEq({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    checkEq({tag, " latency"}, 32'(edges), 32'(expLat));
    checkEq({tag, " quotient"}, bus.zlowOut, expQ);
    checkEq({tag, " remainder"}, bus.zhighOut, expR);
    checkEq({tag, " divByZero"}, 32'(bus.divByZero), 32'(expDz));
    checkEq({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    $display("[TB] %s A=0x%08h B=0x%08h q=0x%08h r=0x%08h dz=%0b edges=%0d",
             tag, a, b, bus.zlowOut, bus.zhighOut, bus.divByZero, edges);
    @(posedge clock); #1;
    checkEq({tag, " done_pulse_width"}, 32'(bus.done), 32'd0);
    checkEq({tag, " quotient_hold"}, bus.zlowOut, expQ);
  endtask

  initial begin
    int doneCount;
    int firstDone;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef SEQ_DIV_UNSIGNED_EN
    bus.unsignedOp = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    checkEq("reset busy", 32'(bus.busy), 32'd0);
    checkEq("reset done", 32'(bus.done), 32'd0);
    checkEq("reset divByZero", 32'(bus.divByZero), 32'd0);
    checkEq("reset zlowOut", bus.zlowOut, 32'd0);
    checkEq("reset zhighOut", bus.zhighOut, 32'd0);
    $display("[TB] reset released");
    clear = 1'b0;
    @(posedge clock); #1;

    runOp("pos_pos",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    runOp("neg_pos",   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33);
    runOp("div_zero",  32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1, 1);
    runOp("overflow",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33);
    runOp("pos_neg",   32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33);
    runOp("neg_neg",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33);
    runOp("neg_zero",  32'hFFFFEDCC,   32'd0,          32'hFFFFFFFF,   32'hFFFFEDCC,   1'b1, 1);
    runOp("small_a",   32'd5,          32'd100,        32'd0,          32'd5,          1'b0, 33);
    runOp("max_pos",   32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 33);
    runOp("min_by_1",  32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33);

    // Extra start pulses during RUN (edge k+10) and coincident with FIX (edge k+33)
    bus.start = 1'b1;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    doneCount = 0;
    firstDone = 0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 10) begin
        bus.start = 1'b1; bus.A = 32'd50; bus.B = 32'd5;
      end
      if (i == 33) begin
        bus.start = 1'b1; bus.A = 32'd9; bus.B = 32'd3;
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        doneCount++;
        if (firstDone == 0) firstDone = i;
      end
    end
    checkEq("restart done_count", 32'(doneCount), 32'd1);
    checkEq("restart done_edge", 32'(firstDone), 32'd33);
    checkEq("restart quotient", bus.zlowOut, 32'd14);
    checkEq("restart remainder", bus.zhighOut, 32'd2);
    checkEq("restart busy_idle", 32'(bus.busy), 32'd0);
    $display("[TB] restart dones=%0d first=%0d q=0x%08h r=0x%08h", doneCount, firstDone, bus.zlowOut, bus.zhighOut);

    // Asynchronous clear partway through an operation
    bus.start = 1'b1;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    checkEq("abort busy", 32'(bus.busy), 32'd0);
    checkEq("abort zlowOut", bus.zlowOut, 32'd0);
    checkEq("abort zhighOut", bus.zhighOut, 32'd0);
    checkEq("abort done", 32'(bus.done), 32'd0);
    #2;
    clear = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) doneCount++;
    end
    checkEq("abort no_done", 32'(doneCount), 32'd0);
    checkEq("abort busy_stays_low", 32'(bus.busy), 32'd0);
    $display("[TB] abort busy=%0b q=0x%08h r=0x%08h dones=%0d", bus.busy, bus.zlowOut, bus.zhighOut, doneCount);

    runOp("after_abort", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

`ifdef SEQ_DIV_UNSIGNED_EN
    bus.unsignedOp = 1'b1;
    runOp("uns_max",  32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1,        1'b0, 33);
    runOp("uns_zero", 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 1);
    bus.unsignedOp = 1'b0;
    runOp("signed_again", 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0, 33);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
